// File: rtl/deadlock_mon_pkg.sv
// deadlock_mon_pkg: shared FSM state type and snapshot helpers for the AXIS deadlock monitors
package deadlock_mon_pkg;
  typedef enum logic [1:0] {IDLE, PEND, BLOCKED} state_e;
  function automatic logic [31:0] info_field(input int k);
    return ~(32'd1 << k);
  endfunction
  function automatic int lowest_set(input logic [63:0] v, input int n);
    int r = n;
    for (int i = 63; i >= 0; i--) if (i < n && v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/deadlock_persist_filter.sv
// deadlock_persist_filter: raw -> qualified block FSM (ports: clock, reset_n as reset, clear, raw in; block registered, block_nxt next-state out)
module deadlock_persist_filter
  import deadlock_mon_pkg::*;
#(
  parameter int THRESH = 16,
  parameter bit STICKY = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic raw,
  output logic block,
  output logic block_nxt
);
  localparam int PW = $clog2(THRESH + 1);
  state_e state, state_d;
  logic [PW-1:0] persist_cnt, cnt_d;
  always_comb begin
    state_d = state;
    cnt_d = persist_cnt;
    if (clear) begin
      state_d = IDLE;
      cnt_d = '0;
    end else
      case (state)
        IDLE: if (raw) begin
          state_d = THRESH == 1 ? BLOCKED : PEND;
          cnt_d = THRESH == 1 ? '0 : PW'(1);
        end
        PEND: begin
          state_d = !raw ? IDLE : persist_cnt == PW'(THRESH - 1) ? BLOCKED : PEND;
          cnt_d = (!raw || persist_cnt == PW'(THRESH - 1)) ? '0 : persist_cnt + PW'(1);
        end
        BLOCKED: state_d = (!STICKY && !raw) ? IDLE : BLOCKED;
        default: state_d = IDLE;
      endcase
  end
  assign block_nxt = state_d == BLOCKED;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      persist_cnt <= '0;
      block <= 1'b0;
    end else begin
      state <= state_d;
      persist_cnt <= cnt_d;
      block <= block_nxt;
    end
endmodule

// File: rtl/axis_deadlock_monitor_param.sv
// axis_deadlock_monitor_param: filtered deadlock flag with stall snapshot, first stalled channel and saturating blocked-cycle count
module axis_deadlock_monitor_param
  import deadlock_mon_pkg::*;
#(
  parameter int N_AXIS = 3,
  parameter int N_INST = 2,
  parameter int N_SUB  = 1,
  parameter int THRESH = 16,
  parameter int CNT_W  = 16,
  parameter bit STICKY = 1'b1,
  parameter int IDX_W  = $clog2(N_AXIS + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       monitor_en,
  input  logic                       clear,
  input  logic [N_AXIS-1:0]          axis_block_sigs,
  input  logic [N_INST-1:0]          inst_idle_sigs,
  input  logic [N_SUB-1:0]           sub_block_sigs,
  output logic [N_AXIS*N_AXIS-1:0]   axis_block_info,
  output logic                       block,
  output logic [IDX_W-1:0]           first_axis_idx,
  output logic [CNT_W-1:0]           block_cycles
);
  logic raw, blk_nxt;
  logic [N_AXIS*N_AXIS-1:0] info_d;
  assign raw = monitor_en & (|axis_block_sigs | |sub_block_sigs) & ~(&inst_idle_sigs);
  deadlock_persist_filter #(.THRESH(THRESH), .STICKY(STICKY)) u_filt (
    .clock(clock), .reset(reset), .clear(clear), .raw(raw), .block(block), .block_nxt(blk_nxt)
  );
  always_comb begin
    info_d = '0;
    for (int k = 0; k < N_AXIS; k++)
      info_d[k*N_AXIS +: N_AXIS] = axis_block_sigs[k] ? N_AXIS'(info_field(k)) : '0;
  end
  // snapshot is taken only on the entering edge and cleared whenever the next state is not BLOCKED
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      axis_block_info <= '0;
      first_axis_idx <= '0;
      block_cycles <= '0;
    end else if (!blk_nxt) begin
      axis_block_info <= '0;
      first_axis_idx <= '0;
      block_cycles <= '0;
    end else if (!block) begin
      axis_block_info <= info_d;
      first_axis_idx <= IDX_W'(lowest_set(64'(axis_block_sigs), N_AXIS));
      block_cycles <= CNT_W'(1);
    end else
      block_cycles <= &block_cycles ? block_cycles : block_cycles + CNT_W'(1);
endmodule

// File: doc/axis_deadlock_monitor_param.md
Name: axis_deadlock_monitor_param

Overview:
- Parametrised deadlock monitor for one HLS top or dataflow region of the cabac co-simulation bench.
- Combines per-channel AXIS stall flags, per-instance idle flags and child-monitor block flags into a filtered, optionally sticky deadlock indication.
- Adds a persistence threshold, a registered per-channel info snapshot, first-blocked-channel capture and a saturating blocked-duration counter.
- Monitors nest: `block` of a child feeds `sub_block_sigs` of its parent.

Parameters:
- N_AXIS, 3, number of monitored AXIS channels (>=1)
- N_INST, 2, number of instance idle flags (>=1)
- N_SUB, 1, number of child-monitor block inputs (>=1)
- THRESH, 16, consecutive raw-block cycles required before `block` asserts (>=1)
- CNT_W, 16, width of blocked-duration counter
- STICKY, 1, 1 = hold BLOCKED until `clear`; 0 = release when raw block drops
- IDX_W, $clog2(N_AXIS+1), width of first-channel index (derived)

Ports:
- clock  in  1  single clock domain
- reset  in  1  asynchronous, active-low reset
- monitor_en  in  1  1 = monitoring active
- clear  in  1  synchronous clear of the blocked state and counters
- axis_block_sigs  in  N_AXIS  bit k = channel k stalled this cycle
- inst_idle_sigs  in  N_INST  bit i = instance i idle
- sub_block_sigs  in  N_SUB  block outputs of child monitors
- axis_block_info  out  N_AXIS*N_AXIS  field k = bits [k*N_AXIS +: N_AXIS]
- block  out  1  deadlock flagged
- first_axis_idx  out  IDX_W  lowest stalled channel at capture; N_AXIS = sub-only cause
- block_cycles  out  CNT_W  cycles spent in BLOCKED, saturating

Behaviour:
- Reset (reset=0, async): FSM=IDLE, persist_cnt=0; all outputs 0.
- Raw block:
  - raw = monitor_en & (|axis_block_sigs | |sub_block_sigs) & ~(&inst_idle_sigs).
  - When all instances are idle, the design is quiescent, not deadlocked.
- FSM states: IDLE, PEND, BLOCKED.
  - IDLE: raw=1 -> PEND with persist_cnt=1. If THRESH==1, raw=1 goes directly to BLOCKED.
  - PEND: raw=0 -> IDLE, persist_cnt=0. raw=1 with persist_cnt==THRESH-1 -> BLOCKED. Otherwise persist_cnt++.
  - Result: `block` is 1 in the cycle after the THRESH-th consecutive raw=1 edge.
  - BLOCKED, STICKY=1: stays until clear=1.
  - BLOCKED, STICKY=0: raw=0 -> IDLE in the next cycle. raw flapping back to 1 restarts PEND; there is no hysteresis.
- clear=1: next state IDLE, persist_cnt=0, block_cycles=0, info=0, first_axis_idx=0. clear overrides any transition in the same cycle. Async reset overrides clear.
- block = (state==BLOCKED), registered.
- Snapshot on the edge entering BLOCKED:
  - Field k of axis_block_info = ~(1<<k) (N_AXIS bits) if axis_block_sigs[k]=1, else 0.
  - first_axis_idx = lowest k with axis_block_sigs[k]=1, or N_AXIS if none.
  - The snapshot is held constant while in BLOCKED; new stalls are not merged.
  - All snapshot outputs read 0 when not BLOCKED.
- block_cycles: 1 on the first BLOCKED cycle, increments each further BLOCKED cycle, saturates at 2^CNT_W-1. It is zeroed on leaving BLOCKED.
- monitor_en=0: raw=0, so PEND returns to IDLE. A sticky BLOCKED state is held; its counter keeps running.
- Reset mid-PEND or mid-BLOCKED: immediate return to reset values, with no glitch on deassertion.

Decomposition:
- Shared package `deadlock_mon_pkg`:
  - state enum (IDLE/PEND/BLOCKED)
  - function computing the info field ~(1<<k)
  - function for lowest-set-bit index with sentinel
- Sub-module `deadlock_persist_filter`: raw -> qualified-block FSM plus persist_cnt, parameterised by THRESH and STICKY.
- Top module: reduction logic, snapshot registers, block_cycles counter.

Test Plan:
- N_AXIS=3, THRESH=4, STICKY=1; axis_block_sigs=3'b010 for 4 cycles, inst_idle=2'b00 -> block=1 on cycle 5; axis_block_info=9'b000_101_000; first_axis_idx=1; block_cycles=1, then 2, 3...
- Same setup; stall held 3 cycles, then 0 -> block never asserts; FSM back to IDLE, persist_cnt=0.
- inst_idle_sigs=2'b11 with axis_block_sigs=3'b111 for 50 cycles -> block stays 0.
- STICKY=0, THRESH=1; sub_block_sigs=1 for 1 cycle, axis=0 -> block=1 for 1 cycle; first_axis_idx=3; info=0; then block=0.
- STICKY=1, blocked with axis=3'b101, then clear=1 while raw=1 -> next cycle block=0, block_cycles=0; re-blocks after THRESH further cycles.
- CNT_W=4 held blocked 20 cycles -> block_cycles saturates at 15. Reset=0 asserted mid-count -> all outputs 0 asynchronously.
